// File: rtl/axi4lite_arbiter.sv
// Two-requester front end onto one AXI4-Lite slave; one transaction in flight at a time.
// Define ARB_FIXED_PRIO_EN to make requester 0 win every tie instead of round-robin.
module axi4lite_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    A_CLK,
  input  logic                    A_RSTn,
  input  logic [1:0]              REQ_VALID,
  output logic [1:0]              REQ_READY,
  input  logic [1:0]              REQ_WRITE,
  input  logic [2*ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [2*DATA_WIDTH-1:0] REQ_WDATA,
  output logic [1:0]              RSP_VALID,
  output logic [DATA_WIDTH-1:0]   RSP_DATA,
  output logic [1:0]              RSP_RESP,
  output logic                    AW_VALID,
  input  logic                    AW_READY,
  output logic [ADDR_WIDTH-1:0]   AW_ADDR,
  output logic                    W_VALID,
  input  logic                    W_READY,
  output logic [DATA_WIDTH-1:0]   W_DATA,
  input  logic                    B_VALID,
  output logic                    B_READY,
  input  logic [1:0]              B_RESP,
  output logic                    AR_VALID,
  input  logic                    AR_READY,
  output logic [ADDR_WIDTH-1:0]   AR_ADDR,
  input  logic                    R_VALID,
  output logic                    R_READY,
  input  logic [DATA_WIDTH-1:0]   R_DATA,
  input  logic [1:0]              R_RESP
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_RSP     = 3'd5;

  logic [2:0]            state_q, state_d;
  logic                  last_q, last_d;
  logic                  gnt_q, gnt_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  pick;
  logic                  aw_now, w_now;

  // A lone requester always wins; a tie goes to whoever did not win last.
`ifdef ARB_FIXED_PRIO_EN
  assign pick = ~REQ_VALID[0];
`else
  assign pick = (&REQ_VALID) ? ~last_q : REQ_VALID[1];
`endif

  assign REQ_READY = (state_q == S_IDLE && |REQ_VALID) ? (pick ? 2'b10 : 2'b01) : 2'b00;
  assign RSP_VALID = (state_q == S_RSP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;

  assign AW_VALID = (state_q == S_WR) && !aw_done_q;
  assign W_VALID  = (state_q == S_WR) && !w_done_q;
  assign B_READY  = (state_q == S_WR_RESP);
  assign AR_VALID = (state_q == S_RD_ADDR);
  assign R_READY  = (state_q == S_RD_DATA);

  assign AW_ADDR  = addr_q;
  assign AR_ADDR  = addr_q;
  assign W_DATA   = wdata_q;
  assign RSP_DATA = rsp_data_q;
  assign RSP_RESP = rsp_resp_q;

  // A handshake in the current cycle already counts toward leaving WR.
  assign aw_now = aw_done_q | (AW_VALID & AW_READY);
  assign w_now  = w_done_q | (W_VALID & W_READY);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    rsp_data_d = rsp_data_q;
    rsp_resp_d = rsp_resp_q;
    case (state_q)
      S_IDLE: begin
        if (|REQ_VALID) begin
          gnt_d   = pick;
          last_d  = pick;
          write_d = REQ_WRITE[pick];
          addr_d  = pick ? REQ_ADDR[2*ADDR_WIDTH-1:ADDR_WIDTH] : REQ_ADDR[ADDR_WIDTH-1:0];
          wdata_d = pick ? REQ_WDATA[2*DATA_WIDTH-1:DATA_WIDTH] : REQ_WDATA[DATA_WIDTH-1:0];
          state_d = REQ_WRITE[pick] ? S_WR : S_RD_ADDR;
        end
      end
      S_WR: begin
        if (aw_now && w_now) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WR_RESP;
        end else begin
          aw_done_d = aw_now;
          w_done_d  = w_now;
        end
      end
      S_WR_RESP: begin
        if (B_VALID) begin
          rsp_resp_d = B_RESP;
          rsp_data_d = '0;
          state_d    = S_RSP;
        end
      end
      S_RD_ADDR: begin
        if (AR_READY) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (R_VALID) begin
          rsp_data_d = R_DATA;
          rsp_resp_d = R_RESP;
          state_d    = S_RSP;
        end
      end
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // last_q resets to 1 so requester 0 takes the first tie.
  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      gnt_q      <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_resp_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      rsp_data_q <= rsp_data_d;
      rsp_resp_q <= rsp_resp_d;
    end
  end

endmodule

// File: tb/tb_axi4lite_arbiter.sv
// Bench for axi4lite_arbiter: transaction-level model plus a configurable-latency slave.
// Honours ARB_FIXED_PRIO_EN in its arbitration expectations.
module tb_axi4lite_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          A_CLK, A_RSTn;
  logic [1:0]    REQ_VALID, REQ_READY, REQ_WRITE;
  logic [2*AW-1:0] REQ_ADDR;
  logic [2*DW-1:0] REQ_WDATA;
  logic [1:0]    RSP_VALID, RSP_RESP;
  logic [DW-1:0] RSP_DATA;
  logic          AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
  logic          AR_VALID, AR_READY, R_VALID, R_READY;
  logic [AW-1:0] AW_ADDR, AR_ADDR;
  logic [DW-1:0] W_DATA, R_DATA;
  logic [1:0]    B_RESP, R_RESP;
  logic [159:0]  allOuts;

  int checks = 0;
  int errors = 0;

  int awWait, wWait, arWait, bWait, rWait;
  logic [1:0]    bRespCfg, rRespCfg;
  logic [DW-1:0] rDataCfg;

  int   cyc = 0;
  int   grantLog[$];
  int   acceptCyc, rspCyc, awHsCyc, wHsCyc, dutRspCount;
  int   awCycles, wCycles, bCycles;
  logic [1:0]    lastRspVec, lastRspResp;
  logic [DW-1:0] lastRspData;

  axi4lite_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .A_CLK(A_CLK), .A_RSTn(A_RSTn),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_RESP(RSP_RESP),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP)
  );

  assign allOuts = {21'd0, REQ_READY, RSP_VALID, RSP_DATA, RSP_RESP, AW_VALID, AW_ADDR,
                    W_VALID, W_DATA, B_READY, AR_VALID, AR_ADDR, R_READY};

  initial begin
    A_CLK = 1'b0;
    forever #5 A_CLK = ~A_CLK;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [159:0] actual, input logic [159:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Slave: each READY/VALID answers after the configured number of waiting cycles.
  initial begin : slaveModel
    int awSeen, wSeen, arSeen, bSeen, rSeen;
    awSeen = 0; wSeen = 0; arSeen = 0; bSeen = 0; rSeen = 0;
    AW_READY = 0; W_READY = 0; AR_READY = 0; B_VALID = 0; R_VALID = 0;
    B_RESP = 0; R_RESP = 0; R_DATA = 0;
    forever begin
      @(negedge A_CLK);
      if (!A_RSTn) begin
        AW_READY = 0; W_READY = 0; AR_READY = 0; B_VALID = 0; R_VALID = 0;
        awSeen = 0; wSeen = 0; arSeen = 0; bSeen = 0; rSeen = 0;
      end else begin
        if (AW_VALID) begin AW_READY = (awSeen >= awWait); awSeen++; end
        else begin AW_READY = 0; awSeen = 0; end
        if (W_VALID) begin W_READY = (wSeen >= wWait); wSeen++; end
        else begin W_READY = 0; wSeen = 0; end
        if (AR_VALID) begin AR_READY = (arSeen >= arWait); arSeen++; end
        else begin AR_READY = 0; arSeen = 0; end
        if (B_READY) begin B_VALID = (bSeen >= bWait); bSeen++; end
        else begin B_VALID = 0; bSeen = 0; end
        if (R_READY) begin R_VALID = (rSeen >= rWait); rSeen++; end
        else begin R_VALID = 0; rSeen = 0; end
        B_RESP = bRespCfg;
        R_RESP = rRespCfg;
        R_DATA = rDataCfg;
      end
    end
  end

  // Transaction model: who is owed a response, and which AXI phase is still pending.
  initial begin : compareProc
    logic mBusy, mRspDue, mWrite, mReq, mLast, mAwDone, mWDone, mArDone, g;
    logic expAw, expW, expB, expAr, expR;
    logic [1:0] expReady;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mWdata, mRspData;
    logic [1:0] mRspResp;
    mBusy = 0; mRspDue = 0; mWrite = 0; mReq = 0; mLast = 1;
    mAwDone = 0; mWDone = 0; mArDone = 0; mAddr = 0; mWdata = 0; mRspData = 0; mRspResp = 0;
    forever begin
      @(negedge A_CLK);
      #2;
      cyc++;
      if (!A_RSTn) begin
        checkOutput("resetOutputs", allOuts, 160'd0);
        mBusy = 0; mRspDue = 0; mLast = 1;
      end else begin
        g = 1'b0;
        expReady = 2'b00;
        if (!mBusy && REQ_VALID != 2'b00) begin
          if (REQ_VALID == 2'b11) begin
`ifdef ARB_FIXED_PRIO_EN
            g = 1'b0;
`else
            g = !mLast;
`endif
          end else begin
            g = REQ_VALID[1];
          end
          expReady = g ? 2'b10 : 2'b01;
        end
        checkOutput("reqReady", REQ_READY, expReady);
        checkOutput("rspValid", RSP_VALID, mRspDue ? (mReq ? 2'b10 : 2'b01) : 2'b00);
        if (mRspDue) begin
          checkOutput("rspData", RSP_DATA, mRspData);
          checkOutput("rspResp", RSP_RESP, mRspResp);
        end
        if (RSP_VALID != 2'b00) begin
          dutRspCount++;
          rspCyc = cyc;
          lastRspVec = RSP_VALID;
          lastRspData = RSP_DATA;
          lastRspResp = RSP_RESP;
        end
        expAw = mBusy && !mRspDue && mWrite && !mAwDone;
        expW  = mBusy && !mRspDue && mWrite && !mWDone;
        expB  = mBusy && !mRspDue && mWrite && mAwDone && mWDone;
        expAr = mBusy && !mRspDue && !mWrite && !mArDone;
        expR  = mBusy && !mRspDue && !mWrite && mArDone;
        checkOutput("awValid", AW_VALID, expAw);
        checkOutput("wValid", W_VALID, expW);
        checkOutput("bReady", B_READY, expB);
        checkOutput("arValid", AR_VALID, expAr);
        checkOutput("rReady", R_READY, expR);
        if (AW_VALID) checkOutput("awAddr", AW_ADDR, mAddr);
        if (W_VALID) checkOutput("wData", W_DATA, mWdata);
        if (AR_VALID) checkOutput("arAddr", AR_ADDR, mAddr);
        if (AW_VALID) awCycles++;
        if (W_VALID) wCycles++;
        if (B_READY) bCycles++;

        if (mRspDue) begin
          mRspDue = 0;
          mBusy = 0;
        end else if (mBusy) begin
          if (expB && B_VALID) begin mRspDue = 1; mRspData = 0; mRspResp = B_RESP; end
          if (expAw && AW_READY) begin mAwDone = 1; awHsCyc = cyc; end
          if (expW && W_READY) begin mWDone = 1; wHsCyc = cyc; end
          if (expR && R_VALID) begin mRspDue = 1; mRspData = R_DATA; mRspResp = R_RESP; end
          if (expAr && AR_READY) mArDone = 1;
        end else if (expReady != 2'b00) begin
          mBusy = 1; mReq = g; mLast = g;
          mWrite = REQ_WRITE[g];
          mAddr = g ? REQ_ADDR[2*AW-1:AW] : REQ_ADDR[AW-1:0];
          mWdata = g ? REQ_WDATA[2*DW-1:DW] : REQ_WDATA[DW-1:0];
          mAwDone = 0; mWDone = 0; mArDone = 0;
          grantLog.push_back(g ? 1 : 0);
          acceptCyc = cyc;
        end
      end
    end
  end

  task automatic applyStimulus(input int req, input logic wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data);
    int n;
    @(negedge A_CLK);
    if (req == 0) begin REQ_ADDR[AW-1:0] = addr; REQ_WDATA[DW-1:0] = data; end
    else begin REQ_ADDR[2*AW-1:AW] = addr; REQ_WDATA[2*DW-1:DW] = data; end
    REQ_WRITE[req] = wr;
    REQ_VALID[req] = 1'b1;
    n = 0;
    #1;
    while (!REQ_READY[req] && n < 100) begin @(negedge A_CLK); #1; n++; end
    checkOutput("accepted", REQ_READY[req], 1'b1);
    @(negedge A_CLK);
    REQ_VALID[req] = 1'b0;
  endtask

  task automatic waitRsp(input int start, input int want);
    int n;
    n = 0;
    while (dutRspCount < start + want && n < 200) begin @(negedge A_CLK); #3; n++; end
    checkOutput("rspSeen", dutRspCount - start, want);
  endtask

  initial begin : mainStim
    int startRsp, base, n;
    A_RSTn = 0; REQ_VALID = 0; REQ_WRITE = 0; REQ_ADDR = 0; REQ_WDATA = 0;
    awWait = 0; wWait = 0; arWait = 0; bWait = 0; rWait = 0;
    bRespCfg = 0; rRespCfg = 0; rDataCfg = 0;
    dutRspCount = 0; awCycles = 0; wCycles = 0; bCycles = 0;
    acceptCyc = 0; rspCyc = 0; awHsCyc = 0; wHsCyc = 0;
    lastRspVec = 0; lastRspData = 0; lastRspResp = 0;
    repeat (2) @(negedge A_CLK);
    #1 checkOutput("resetState", allOuts, 160'd0);
    @(negedge A_CLK);
    A_RSTn = 1;

    $display("[TB] write from requester 0, slave always ready");
    startRsp = dutRspCount;
    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF);
    waitRsp(startRsp, 1);
    checkOutput("t1Latency", rspCyc - acceptCyc, 3);
    checkOutput("t1AwHs", awHsCyc - acceptCyc, 1);
    checkOutput("t1WHs", wHsCyc - acceptCyc, 1);
    checkOutput("t1RspVec", lastRspVec, 2'b01);
    checkOutput("t1RspData", lastRspData, 32'h0);
    checkOutput("t1RspResp", lastRspResp, 2'b00);

    $display("[TB] read from requester 1");
    rDataCfg = 32'h12345678;
    startRsp = dutRspCount;
    applyStimulus(1, 1'b0, 32'h20, 32'h0);
    waitRsp(startRsp, 1);
    checkOutput("t2Latency", rspCyc - acceptCyc, 3);
    checkOutput("t2RspVec", lastRspVec, 2'b10);
    checkOutput("t2RspData", lastRspData, 32'h12345678);

    $display("[TB] both requesters valid for four transactions");
    rDataCfg = 32'h0BADF00D;
    startRsp = dutRspCount;
    base = grantLog.size();
    @(negedge A_CLK);
    REQ_ADDR = {32'h204, 32'h104};
    REQ_WRITE = 2'b00;
    REQ_VALID = 2'b11;
    n = 0;
    while (grantLog.size() < base + 4 && n < 200) begin @(negedge A_CLK); #3; n++; end
    @(negedge A_CLK);
    REQ_VALID = 2'b00;
    waitRsp(startRsp, 4);
    checkOutput("t3Grants", grantLog.size() - base, 4);
`ifdef ARB_FIXED_PRIO_EN
    checkOutput("t3Grant0", grantLog[base], 0);
    checkOutput("t3Grant1", grantLog[base+1], 0);
    checkOutput("t3Grant2", grantLog[base+2], 0);
    checkOutput("t3Grant3", grantLog[base+3], 0);
`else
    checkOutput("t3Grant0", grantLog[base], 0);
    checkOutput("t3Grant1", grantLog[base+1], 1);
    checkOutput("t3Grant2", grantLog[base+2], 0);
    checkOutput("t3Grant3", grantLog[base+3], 1);
`endif

    $display("[TB] write with AW_READY held off");
    awWait = 2;
    awCycles = 0; wCycles = 0; bCycles = 0;
    startRsp = dutRspCount;
    applyStimulus(0, 1'b1, 32'h40, 32'hA5A50004);
    waitRsp(startRsp, 1);
    repeat (3) @(negedge A_CLK);
    checkOutput("t4AwCycles", awCycles, 3);
    checkOutput("t4WCycles", wCycles, 1);
    checkOutput("t4BCycles", bCycles, 1);
    checkOutput("t4RspPulses", dutRspCount - startRsp, 1);
    awWait = 0;

    $display("[TB] read with SLVERR response");
    rRespCfg = 2'b10; rWait = 1; rDataCfg = 32'hCAFE0005;
    startRsp = dutRspCount;
    applyStimulus(1, 1'b0, 32'h50, 32'h0);
    waitRsp(startRsp, 1);
    checkOutput("t5RspVec", lastRspVec, 2'b10);
    checkOutput("t5RspResp", lastRspResp, 2'b10);
    checkOutput("t5RspData", lastRspData, 32'hCAFE0005);
    rRespCfg = 2'b00;

    $display("[TB] reset during read data phase");
    rWait = 20;
    startRsp = dutRspCount;
    applyStimulus(0, 1'b0, 32'h60, 32'h0);
    n = 0;
    while (!R_READY && n < 50) begin @(negedge A_CLK); #3; n++; end
    checkOutput("t6InRdData", R_READY, 1'b1);
    A_RSTn = 0;
    #1 checkOutput("t6ResetOutputs", allOuts, 160'd0);
    repeat (3) @(negedge A_CLK);
    A_RSTn = 1;
    rWait = 0;
    repeat (5) @(negedge A_CLK);
    checkOutput("t6NoRsp", dutRspCount - startRsp, 0);
    base = grantLog.size();
    REQ_ADDR = {32'h270, 32'h170};
    REQ_WRITE = 2'b00;
    REQ_VALID = 2'b11;
    n = 0;
    while (grantLog.size() == base && n < 20) begin @(negedge A_CLK); #3; n++; end
    @(negedge A_CLK);
    REQ_VALID = 2'b00;
    checkOutput("t6Granted", grantLog.size() - base, 1);
    checkOutput("t6TieWinner", grantLog[base], 0);
    waitRsp(startRsp, 1);
    checkOutput("t6RspVec", lastRspVec, 2'b01);

    repeat (2) @(negedge A_CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
